// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the RV32 multicycle instruction-fetch stage:
// data width, fetch FSM encoding, opcode constants and the PC update helper.
package busca_instrucao_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] END_OF_PROGRAM = 32'h0000_0000;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

    // Sequential step or beq-taken target; the adder wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] calc_next_pc(
        input logic [XLEN-1:0] pc,
        input logic            pcsrc,
        input logic [12:0]     branch_off
    );
        logic [XLEN-1:0] w_off;
        w_off = {{(XLEN-13){branch_off[12]}}, branch_off};
        return pcsrc ? (pc + w_off) : (pc + 32'd4);
    endfunction

endpackage

// File: rtl/busca_instrucao_if.sv
// Request/response bundle between the top-level control FSM (master)
// and the instruction-fetch stage (slave).
interface busca_instrucao_if;
    import busca_instrucao_pkg::*;

    logic            fetch_req;
    logic            pc_update;
    logic            pcsrc;
    logic [12:0]     branch_off;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instrucao;
    logic            instr_valid;
    logic            busy;
    logic            halted;
    logic            misaligned;

    modport master (
        output fetch_req, pc_update, pcsrc, branch_off,
        input  pc, instrucao, instr_valid, busy, halted, misaligned
    );

    modport slave (
        input  fetch_req, pc_update, pcsrc, branch_off,
        output pc, instrucao, instr_valid, busy, halted, misaligned
    );

endinterface

// File: rtl/busca_instrucao_rom_instrucoes.sv
// Registered-output instruction ROM, DEPTH x 32; the program image is a packed
// constant with word i at bits [32*i +: 32]. Data appears one cycle after i_en.
module rom_instrucoes #(
    parameter int                   DEPTH      = 32,
    parameter int                   AW         = $clog2(DEPTH),
    parameter logic [DEPTH*32-1:0]  INIT_IMAGE = '0
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [AW-1:0] i_addr,
    output logic [31:0]   o_data
);

    logic [31:0] r_data;

    // NOTE: the image is a constant, so there is no storage to reset; the
    // output register is only loaded when enabled and is never reset either.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_data <= INIT_IMAGE[i_addr*32 +: 32];
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: owns the PC and instruction ROM, serves one fetch per
// request with MEM_LAT wait cycles, applies PC updates and raises sticky halt flags.
module busca_instrucao
    import busca_instrucao_pkg::*;
#(
    parameter int                  DEPTH      = 32,
    parameter int                  MEM_LAT    = 2,
    parameter logic [XLEN-1:0]     PC_RESET   = 32'h0000_0000,
    parameter logic [DEPTH*32-1:0] INIT_IMAGE = '0
) (
    input  logic            clk,
    input  logic            rst,
    busca_instrucao_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MEM_LAT + 1);

    fetch_state_t    r_state;
    fetch_state_t    w_next;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-3:0] r_idx;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_instrucao;
    logic            r_halted;
    logic            r_misaligned;

    logic [XLEN-1:0] w_pc_cand;
    logic            w_pc_bad;
    logic            w_pc_step;
    logic            w_fetch_start;
    logic            w_done_entry;
    logic            w_in_range;
    logic            w_rom_en;
    logic [31:0]     w_rom_data;

    assign w_pc_cand     = calc_next_pc(r_pc, bus.pcsrc, bus.branch_off);
    assign w_pc_bad      = (w_pc_cand[1:0] != 2'b00);
    assign w_pc_step     = (r_state == ST_IDLE) && bus.pc_update;
    assign w_fetch_start = (r_state == ST_IDLE) && bus.fetch_req && !bus.pc_update;
    assign w_done_entry  = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_in_range    = (r_idx < (XLEN-2)'(DEPTH));
    assign w_rom_en      = (r_state == ST_WAIT) && w_in_range;

    rom_instrucoes #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .INIT_IMAGE (INIT_IMAGE)
    ) u_rom (
        .clk    (clk),
        .i_en   (w_rom_en),
        .i_addr (r_idx[AW-1:0]),
        .o_data (w_rom_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next takes a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.pc_update) begin
                    if (w_pc_bad) begin
                        w_next = ST_HALT;
                    end
                end else if (bus.fetch_req) begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = (r_instrucao == END_OF_PROGRAM) ? ST_HALT : ST_IDLE;
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.pc          = r_pc;
        bus.instrucao   = r_instrucao;
        bus.instr_valid = (r_state == ST_DONE);
        bus.busy        = (r_state == ST_WAIT);
        bus.halted      = r_halted;
        bus.misaligned  = r_misaligned;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= PC_RESET;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_instrucao  <= '0;
            r_halted     <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            // A misaligned branch target leaves the PC where it was.
            if (w_pc_step) begin
                if (w_pc_bad) begin
                    r_misaligned <= 1'b1;
                    r_halted     <= 1'b1;
                end else begin
                    r_pc <= w_pc_cand;
                end
            end

            if (w_fetch_start) begin
                r_idx <= r_pc[XLEN-1:2];
                r_cnt <= CW'(MEM_LAT);
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_done_entry) begin
                r_instrucao <= w_in_range ? w_rom_data : END_OF_PROGRAM;
            end

            if ((r_state == ST_DONE) && (r_instrucao == END_OF_PROGRAM)) begin
                r_halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: latency, PC update, misaligned branch,
// out-of-range fetch, reset abort and ignored requests.
module tb_busca_instrucao;

    localparam int DEPTH   = 32;
    localparam int MEM_LAT = 2;
    localparam int LAT     = MEM_LAT + 1;

    localparam logic [31:0] W0 = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] W1 = 32'h0010_0113;  // addi x2,x0,1
    localparam logic [31:0] W2 = 32'h4020_81b3;  // sub  x3,x1,x2
    localparam logic [31:0] W3 = 32'h0020_c233;  // xor  x4,x1,x2
    localparam logic [DEPTH*32-1:0] IMAGE = {896'h0, W3, W2, W1, W0};

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    busca_instrucao_if bus ();

    busca_instrucao #(
        .DEPTH      (DEPTH),
        .MEM_LAT    (MEM_LAT),
        .PC_RESET   (32'h0000_0000),
        .INIT_IMAGE (IMAGE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic step_pc(input logic src, input logic [12:0] off);
        bus.pc_update  = 1'b1;
        bus.pcsrc      = src;
        bus.branch_off = off;
        tick();
        bus.pc_update  = 1'b0;
        bus.pcsrc      = 1'b0;
        bus.branch_off = '0;
    endtask

    // Issues a one-cycle fetch_req and returns the cycles from the sampling
    // edge until instr_valid is seen, bounded so a dead DUT cannot hang the run.
    task automatic fetch(output int lat);
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        lat = 0;
        while (!bus.instr_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.instr_valid) n++;
        end
    endtask

    initial begin
        int lat;
        int n;
        logic [31:0] seen;

        errors         = 0;
        checks         = 0;
        rst            = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.pc_update  = 1'b0;
        bus.pcsrc      = 1'b0;
        bus.branch_off = '0;

        // 1: reset state and first fetch latency
        do_reset();
        check("rst_pc", bus.pc, 32'h0);
        check("rst_instr", bus.instrucao, 32'h0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_misal", 32'(bus.misaligned), 32'd0);
        fetch(lat);
        check("t1_lat", 32'(lat), 32'(LAT));
        check("t1_instr", bus.instrucao, W0);
        check("t1_pc", bus.pc, 32'h0);
        check("t1_busy_done", 32'(bus.busy), 32'd0);
        tick();
        check("t1_pulse", 32'(bus.instr_valid), 32'd0);
        check("t1_halted", 32'(bus.halted), 32'd0);

        // 2: sequential steps and a backward branch
        for (int i = 0; i < 4; i++) step_pc(1'b0, 13'h0);
        check("t2_pc16", bus.pc, 32'd16);
        step_pc(1'b1, 13'h1FF8);
        check("t2_pc8", bus.pc, 32'd8);

        // 6a: simultaneous update and fetch -> update wins
        bus.fetch_req = 1'b1;
        step_pc(1'b0, 13'h0);
        bus.fetch_req = 1'b0;
        check("t6_pc12", bus.pc, 32'd12);
        check("t6_nobusy", 32'(bus.busy), 32'd0);
        tick();
        check("t6_nobusy2", 32'(bus.busy), 32'd0);

        // 6b: requests during WAIT are ignored, one pulse only, pc stable
        bus.fetch_req = 1'b1;
        tick();
        check("t6_busy", 32'(bus.busy), 32'd1);
        bus.pc_update = 1'b1;
        tick();
        tick();
        bus.fetch_req = 1'b0;
        bus.pc_update = 1'b0;
        check("t6_pc_wait", bus.pc, 32'd12);
        n    = 0;
        seen = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.instr_valid) begin
                n++;
                seen = bus.instrucao;
            end
        end
        check("t6_pulses", 32'(n), 32'd1);
        check("t6_instr", seen, W3);
        check("t6_pc_after", bus.pc, 32'd12);

        // 3: misaligned branch target halts and freezes pc
        do_reset();
        step_pc(1'b0, 13'h0);
        check("t3_pc4", bus.pc, 32'd4);
        step_pc(1'b1, 13'h0006);
        check("t3_misal", 32'(bus.misaligned), 32'd1);
        check("t3_halted", 32'(bus.halted), 32'd1);
        check("t3_pc", bus.pc, 32'd4);
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        check("t3_nobusy", 32'(bus.busy), 32'd0);
        count_valid(6, n);
        check("t3_novalid", 32'(n), 32'd0);

        // 4: fetch beyond the ROM returns zero and halts
        do_reset();
        check("t4_clear", 32'(bus.halted), 32'd0);
        step_pc(1'b1, 13'h0080);
        check("t4_pc128", bus.pc, 32'd128);
        fetch(lat);
        check("t4_lat", 32'(lat), 32'(LAT));
        check("t4_instr", bus.instrucao, 32'h0);
        tick();
        check("t4_halted", 32'(bus.halted), 32'd1);
        check("t4_misal", 32'(bus.misaligned), 32'd0);
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        check("t4_ignored", 32'(bus.busy), 32'd0);

        // 5: reset in the second WAIT cycle aborts the fetch
        do_reset();
        step_pc(1'b0, 13'h0);
        fetch(lat);
        check("t5_pre_instr", bus.instrucao, W1);
        tick();
        do_reset();
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        tick();
        check("t5_wait2", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_valid", 32'(bus.instr_valid), 32'd0);
        check("t5_pc", bus.pc, 32'h0);
        check("t5_instr", bus.instrucao, 32'h0);
        count_valid(5, n);
        check("t5_novalid", 32'(n), 32'd0);
        fetch(lat);
        check("t5_lat", 32'(lat), 32'(LAT));
        check("t5_refetch", bus.instrucao, W0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
